// File: rtl/ex_operand_fwd.sv
// EX-stage operand selector: picks rs1/rs2 from MA, WB, delayed-WB or register file, combinationally.
// A stall freezes each operand's selected value in a hold register until EX advances or the pipe is flushed.
module ex_operand_fwd #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hit_rs1_idex_ex,
    input  logic            hit_rs1_idma_ex,
    input  logic            hit_rs1_idwb_ex,
    input  logic            nohit_rs1_ex,
    input  logic            hit_rs2_idex_ex,
    input  logic            hit_rs2_idma_ex,
    input  logic            hit_rs2_idwb_ex,
    input  logic            nohit_rs2_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [XLEN-1:0] rd_data_ma,
    input  logic [XLEN-1:0] rd_data_wb,
    input  logic            wbk_rd_reg_wb,
    input  logic            stall,
    input  logic            rst_pipe,
    output logic [XLEN-1:0] rs1_fwd_ex,
    output logic [XLEN-1:0] rs2_fwd_ex,
    output logic            fwd_multi_err
);

    logic [XLEN-1:0] r_wb_d1;
    logic            r_wb_d1_vld;
    logic [XLEN-1:0] r_hold1;
    logic [XLEN-1:0] r_hold2;
    logic            r_held1;
    logic            r_held2;
    logic            r_multi_err;

    logic [XLEN-1:0] w_wb_d1;
    logic [XLEN-1:0] w_sel1;
    logic [XLEN-1:0] w_sel2;
    logic            w_multi1;
    logic            w_multi2;

    // Before the first write-back since reset there is nothing retired to forward.
    assign w_wb_d1 = r_wb_d1_vld ? r_wb_d1 : '0;

    always_comb begin
        w_sel1 = '0;
        if (hit_rs1_idex_ex)      w_sel1 = rd_data_ma;
        else if (hit_rs1_idma_ex) w_sel1 = rd_data_wb;
        else if (hit_rs1_idwb_ex) w_sel1 = w_wb_d1;
        else if (nohit_rs1_ex)    w_sel1 = rs1_data_ex;
    end

    always_comb begin
        w_sel2 = '0;
        if (hit_rs2_idex_ex)      w_sel2 = rd_data_ma;
        else if (hit_rs2_idma_ex) w_sel2 = rd_data_wb;
        else if (hit_rs2_idwb_ex) w_sel2 = w_wb_d1;
        else if (nohit_rs2_ex)    w_sel2 = rs2_data_ex;
    end

    assign w_multi1 = (hit_rs1_idex_ex & (hit_rs1_idma_ex | hit_rs1_idwb_ex | nohit_rs1_ex)) |
                      (hit_rs1_idma_ex & (hit_rs1_idwb_ex | nohit_rs1_ex)) |
                      (hit_rs1_idwb_ex & nohit_rs1_ex);
    assign w_multi2 = (hit_rs2_idex_ex & (hit_rs2_idma_ex | hit_rs2_idwb_ex | nohit_rs2_ex)) |
                      (hit_rs2_idma_ex & (hit_rs2_idwb_ex | nohit_rs2_ex)) |
                      (hit_rs2_idwb_ex & nohit_rs2_ex);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_d1     <= '0;
            r_wb_d1_vld <= 1'b0;
            r_hold1     <= '0;
            r_hold2     <= '0;
            r_held1     <= 1'b0;
            r_held2     <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            // The register file is already updated, so stall/flush never block this copy.
            if (wbk_rd_reg_wb) begin
                r_wb_d1     <= rd_data_wb;
                r_wb_d1_vld <= 1'b1;
            end

            if (rst_pipe) begin
                r_held1 <= 1'b0;
            end else if (stall && !r_held1) begin
                r_hold1 <= w_sel1;
                r_held1 <= 1'b1;
            end else if (!stall) begin
                r_held1 <= 1'b0;
            end

            if (rst_pipe) begin
                r_held2 <= 1'b0;
            end else if (stall && !r_held2) begin
                r_hold2 <= w_sel2;
                r_held2 <= 1'b1;
            end else if (!stall) begin
                r_held2 <= 1'b0;
            end

            if ((w_multi1 && !r_held1) || (w_multi2 && !r_held2))
                r_multi_err <= 1'b1;
        end
    end

    assign rs1_fwd_ex    = r_held1 ? r_hold1 : w_sel1;
    assign rs2_fwd_ex    = r_held2 ? r_hold2 : w_sel2;
    assign fwd_multi_err = r_multi_err;

endmodule
